// File: rtl/hazard_controller.sv
// OTTER hazard controller: RAW stalls, branch flushes, EX forwarding selects.
// Optional macro OTTER_FORWARD_EN: enables EX/MEM forwarding (load-use stalls only).
module hazard_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             DE_VALID,
  input  logic [4:0]       DE_RS1_ADDR,
  input  logic [4:0]       DE_RS2_ADDR,
  input  logic             DE_RS1_USED,
  input  logic             DE_RS2_USED,
  input  logic [4:0]       DE_RD_ADDR,
  input  logic             DE_REG_WRITE,
  input  logic             DE_MEM_READ,
  input  logic             EX_BRANCH_TAKEN,
  output logic             STALL_IF,
  output logic             STALL_DE,
  output logic             FLUSH_IF_DE,
  output logic             BUBBLE_EX,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [1:0]       HAZ_STATE
);

  localparam int FW =
    (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [FW-1:0] F_RELOAD =
    (FLUSH_CYCLES > 1) ? FW'(FLUSH_CYCLES - 2) : '0;
  localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t        state, state_nx;
  logic [FW-1:0] fcnt, fcnt_nx;

  // WB is bypassed by the regfile, so only EX and MEM are stored.
  logic       ex_v, ex_ld, mem_v;
  logic [4:0] ex_rd, mem_rd;

  logic rs1_on, rs2_on;
  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic haz, flush;
  logic ex_load_vis;

  assign rs1_on = DE_VALID & DE_RS1_USED & (DE_RS1_ADDR != 5'd0);
  assign rs2_on = DE_VALID & DE_RS2_USED & (DE_RS2_ADDR != 5'd0);

  assign ex_m1  = rs1_on & ex_v  & (ex_rd  == DE_RS1_ADDR);
  assign ex_m2  = rs2_on & ex_v  & (ex_rd  == DE_RS2_ADDR);
  assign mem_m1 = rs1_on & mem_v & (mem_rd == DE_RS1_ADDR);
  assign mem_m2 = rs2_on & mem_v & (mem_rd == DE_RS2_ADDR);

`ifdef OTTER_FORWARD_EN
  assign haz = (ex_m1 | ex_m2) & ex_ld;
  assign ex_load_vis = 1'b0;
`else
  assign haz = ex_m1 | ex_m2 | mem_m1 | mem_m2;
  assign ex_load_vis = ex_ld;
`endif

  logic unused_ld;
  assign unused_ld = ex_load_vis;

  assign flush = EX_BRANCH_TAKEN | (state == FLUSH);

  // Control outputs; reset forces the front end to flush.
  assign FLUSH_IF_DE = ~RST_N | flush;
  assign BUBBLE_EX   = ~RST_N | flush | haz;
  assign STALL_IF    = RST_N & ~flush & haz;
  assign STALL_DE    = RST_N & ~flush & haz;
  assign HAZ_STATE   = state;

  // Next-state logic for the RUN/STALL/FLUSH sequencer.
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    unique case (state)
      RUN, STALL: begin
        if (EX_BRANCH_TAKEN) begin
          state_nx = MULTI_FLUSH ? FLUSH : RUN;
          fcnt_nx  = F_RELOAD;
        end else if (haz) begin
          state_nx = STALL;
        end else begin
          state_nx = RUN;
        end
      end
      FLUSH: begin
        if (EX_BRANCH_TAKEN) begin
          fcnt_nx = F_RELOAD;
        end else if (fcnt == '0) begin
          state_nx = RUN;
        end else begin
          fcnt_nx = fcnt - 1'b1;
        end
      end
      default: begin
        state_nx = RUN;
        fcnt_nx  = '0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  end

  // Scoreboard shift: DE enters EX unless bubbled, EX moves to MEM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_v   <= 1'b0;
      ex_rd  <= 5'd0;
      ex_ld  <= 1'b0;
      mem_v  <= 1'b0;
      mem_rd <= 5'd0;
    end else begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      ex_v   <= DE_VALID & DE_REG_WRITE
              & (DE_RD_ADDR != 5'd0) & ~BUBBLE_EX;
      ex_rd  <= DE_RD_ADDR;
      ex_ld  <= DE_MEM_READ;
    end
  end

  // Saturating count of cycles lost to RAW stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STALL_CNT <= '0;
    end else if (haz && !flush && (STALL_CNT != '1)) begin
      STALL_CNT <= STALL_CNT + 1'b1;
    end
  end

`ifdef OTTER_FORWARD_EN
  logic [1:0] sel_a, sel_b;

  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    unique case (1'b1)
      ex_m1:   sel_a = 2'b01;
      mem_m1:  sel_a = 2'b10;
      default: sel_a = 2'b00;
    endcase
    unique case (1'b1)
      ex_m2:   sel_b = 2'b01;
      mem_m2:  sel_b = 2'b10;
      default: sel_b = 2'b00;
    endcase
  end

  // Selects follow the instruction entering EX; hold while DE stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FWD_A_SEL <= 2'b00;
      FWD_B_SEL <= 2'b00;
    end else if (!STALL_DE) begin
      FWD_A_SEL <= BUBBLE_EX ? 2'b00 : sel_a;
      FWD_B_SEL <= BUBBLE_EX ? 2'b00 : sel_b;
    end
  end
`else
  assign FWD_A_SEL = 2'b00;
  assign FWD_B_SEL = 2'b00;
`endif

endmodule
